// File: rtl/reg_bus_master.sv
// reg_bus_master
//   Single-outstanding request master for a simple register bus. A request
//   accepted in IDLE is played out as a write (WRITE strobe cycle + WHOLD
//   cycle) or a read (READ_WAIT cycles with cs high, data sampled at the
//   last edge), then a one-cycle response pulse. All outputs are registered.
//
//   Optional build macro: WRITE_VERIFY_EN
//     Adds a VERIFY phase after WHOLD that reads the register back for
//     READ_WAIT cycles and flags a mismatch on any enabled byte.
//
// Parameters
//   READ_WAIT     read/verify cycles with cs high before sampling (1..15)
// Ports
//   bus_clk       clock, rising edge
//   reset         synchronous, active-high
//   req_valid     request present
//   req_ready     request accepted when req_valid & req_ready at an edge
//   req_read      1 = read, 0 = write
//   req_addr      register address
//   req_data      write data
//   req_byte_en   write byte enables (bit N -> byte N), ignored for reads
//   rsp_valid     one-cycle completion pulse
//   rsp_data      read data / readback data, 0 for plain writes
//   rsp_error     write-verify mismatch, valid with rsp_valid
//   cs            bus chip select
//   wr0..wr3      byte write strobes
//   addr          bus address
//   bus_data_out  bus write data
//   bus_data_in   bus read data from the selected slave
module reg_bus_master #(
  parameter int unsigned READ_WAIT = 2
) (
  input  logic        bus_clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_read,
  input  logic [12:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [3:0]  req_byte_en,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_error,
  output logic        cs,
  output logic        wr0,
  output logic        wr1,
  output logic        wr2,
  output logic        wr3,
  output logic [12:0] addr,
  output logic [31:0] bus_data_out,
  input  logic [31:0] bus_data_in
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    WHOLD,
    READ,
    RSP
`ifdef WRITE_VERIFY_EN
    , VERIFY
`endif
  } state_t;

  localparam logic [3:0] LAST_WAIT = 4'(READ_WAIT - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [3:0]  be_q, be_nxt;
  logic        ready_nxt;
  logic        cs_nxt;
  logic [3:0]  wr_nxt;
  logic [12:0] addr_nxt;
  logic [31:0] dout_nxt;
  logic        rsp_valid_nxt;
  logic [31:0] rsp_data_nxt;
  logic        rsp_error_nxt;

`ifdef WRITE_VERIFY_EN
  logic [31:0] be_mask;
  assign be_mask = {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};
`endif

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    be_nxt        = be_q;
    addr_nxt      = addr;
    dout_nxt      = bus_data_out;
    rsp_data_nxt  = rsp_data;
    rsp_error_nxt = rsp_error;

    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          addr_nxt = req_addr;
          be_nxt   = req_byte_en;
          cnt_nxt  = '0;
          if (req_read) begin
            state_nxt = READ;
          end else begin
            dout_nxt  = req_data;
            state_nxt = WRITE;
          end
        end
      end
      WRITE: state_nxt = WHOLD;
      WHOLD: begin
`ifdef WRITE_VERIFY_EN
        state_nxt = VERIFY;
        cnt_nxt   = '0;
`else
        state_nxt     = RSP;
        rsp_data_nxt  = '0;
        rsp_error_nxt = 1'b0;
`endif
      end
      READ: begin
        if (cnt == LAST_WAIT) begin
          state_nxt     = RSP;
          rsp_data_nxt  = bus_data_in;
          rsp_error_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
`ifdef WRITE_VERIFY_EN
      VERIFY: begin
        // bus_data_out still holds the written word, so it is the reference
        if (cnt == LAST_WAIT) begin
          state_nxt     = RSP;
          rsp_data_nxt  = bus_data_in;
          rsp_error_nxt = |((bus_data_in ^ bus_data_out) & be_mask);
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
`endif
      RSP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Registered outputs are derived from the state being entered so that
    // they line up with that state's cycle.
    ready_nxt     = (state_nxt == IDLE);
    cs_nxt        = !((state_nxt == IDLE) || (state_nxt == RSP));
    wr_nxt        = (state_nxt == WRITE) ? be_nxt : '0;
    rsp_valid_nxt = (state_nxt == RSP);
  end

  always_ff @(posedge bus_clk) begin
    if (reset) begin
      state                  <= IDLE;
      cnt                    <= '0;
      be_q                   <= '0;
      req_ready              <= 1'b0;
      cs                     <= 1'b0;
      {wr3, wr2, wr1, wr0}   <= '0;
      addr                   <= '0;
      bus_data_out           <= '0;
      rsp_valid              <= 1'b0;
      rsp_data               <= '0;
      rsp_error              <= 1'b0;
    end else begin
      state                  <= state_nxt;
      cnt                    <= cnt_nxt;
      be_q                   <= be_nxt;
      req_ready              <= ready_nxt;
      cs                     <= cs_nxt;
      {wr3, wr2, wr1, wr0}   <= wr_nxt;
      addr                   <= addr_nxt;
      bus_data_out           <= dout_nxt;
      rsp_valid              <= rsp_valid_nxt;
      rsp_data               <= rsp_data_nxt;
      rsp_error              <= rsp_error_nxt;
    end
  end

endmodule

// File: tb/tb_reg_bus_master.sv
// tb_reg_bus_master
//   Bench for reg_bus_master with READ_WAIT = 3. A transaction-level model
//   predicts every output from acceptance time and fixed latencies; a
//   negedge process compares all outputs each cycle. Directed sections pin
//   the model with literal values, followed by randomized traffic.
module tb_reg_bus_master;

  localparam int unsigned RW = 3;
`ifdef WRITE_VERIFY_EN
  localparam int WLAT      = RW + 2;
  localparam bit VERIFY_EN = 1'b1;
`else
  localparam int WLAT      = 2;
  localparam bit VERIFY_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_read;
  logic [12:0] req_addr;
  logic [31:0] req_data;
  logic [3:0]  req_byte_en;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_error;
  logic        cs;
  logic        wr0, wr1, wr2, wr3;
  logic [12:0] addr;
  logic [31:0] bus_data_out;
  logic [31:0] bus_data_in;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit rand_bus = 1'b0;
  logic [31:0] last_w = '0;

  reg_bus_master #(.READ_WAIT(RW)) dut (
    .bus_clk      (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_read     (req_read),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .req_byte_en  (req_byte_en),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .rsp_error    (rsp_error),
    .cs           (cs),
    .wr0          (wr0),
    .wr1          (wr1),
    .wr2          (wr2),
    .wr3          (wr3),
    .addr         (addr),
    .bus_data_out (bus_data_out),
    .bus_data_in  (bus_data_in)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
    end
  endtask

  // Model: cycle n is the cycle following edge n. A request accepted at
  // edge t drives cs for cycles t .. rsp_at-1, strobes at cycle t (writes),
  // and responds in cycle rsp_at with data sampled at edge rsp_at.
  logic        m_busy = 1'b0, m_ready = 1'b0, m_read = 1'b0;
  int          m_t = 0, m_rsp_at = 0;
  logic [31:0] m_data = '0;
  logic [3:0]  m_be = '0;
  logic        e_cs, e_rv, e_re;
  logic [3:0]  e_wr;
  logic [12:0] e_addr;
  logic [31:0] e_dout, e_rd;

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      if (reset) begin
        m_busy = 0; m_ready = 0; e_cs = 0; e_wr = 0; e_addr = 0;
        e_dout = 0; e_rv = 0; e_rd = 0; e_re = 0;
      end else begin
        if (!m_busy && m_ready && req_valid) begin
          m_busy   = 1;
          m_t      = cyc;
          m_read   = req_read;
          m_data   = req_data;
          m_be     = req_byte_en;
          e_addr   = req_addr;
          if (!req_read) e_dout = req_data;
          m_rsp_at = req_read ? cyc + RW : cyc + WLAT;
        end
        e_rv = 0;
        e_cs = m_busy && (cyc < m_rsp_at);
        e_wr = (m_busy && !m_read && cyc == m_t) ? m_be : 4'h0;
        if (m_busy && cyc == m_rsp_at) begin
          e_rv   = 1;
          m_busy = 0;
          e_re   = 0;
          if (m_read || VERIFY_EN) e_rd = bus_data_in;
          else e_rd = 0;
          if (!m_read && VERIFY_EN)
            for (int i = 0; i < 4; i++)
              if (m_be[i] && (bus_data_in[8*i +: 8] != m_data[8*i +: 8])) e_re = 1;
        end
        m_ready = !m_busy && !e_rv;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cyc >= 1) begin
        chk("req_ready", req_ready, m_ready);
        chk("cs", cs, e_cs);
        chk("wr", {wr3, wr2, wr1, wr0}, e_wr);
        chk("addr", addr, e_addr);
        chk("bus_data_out", bus_data_out, e_dout);
        chk("rsp_valid", rsp_valid, e_rv);
        chk("rsp_data", rsp_data, e_rd);
        chk("rsp_error", rsp_error, e_re);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_bus) bus_data_in = ($urandom_range(0, 1) != 0) ? last_w : $urandom;
  endtask

  task automatic issue(input logic rd, input logic [12:0] a, input logic [31:0] d,
                       input logic [3:0] be, input bit keep, output int t);
    bit got;
    int n;
    got = 0;
    n = 0;
    req_valid = 1; req_read = rd; req_addr = a; req_data = d; req_byte_en = be;
    if (!rd) last_w = d;
    while (!got && n < 64) begin
      got = (req_ready === 1'b1);
      step();
      n++;
    end
    t = cyc;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL accept_timeout cyc=%0d got=no_accept exp=accept", cyc);
    end
    if (!keep) begin
      req_valid   = 0;
      req_read    = 1'($urandom);
      req_addr    = 13'($urandom);
      req_data    = $urandom;
      req_byte_en = 4'($urandom);
    end
  endtask

  initial begin
    int t, t1, t2;
    reset = 1; req_valid = 0; req_read = 0; req_addr = 0; req_data = 0;
    req_byte_en = 0; bus_data_in = 0;
    step(); step();
    chk("rst_cs", cs, 1'b0);
    chk("rst_ready", req_ready, 1'b0);
    chk("rst_addr", addr, 13'h0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    reset = 0;
    step();
    chk("ready_after_rst", req_ready, 1'b1);

    // full-word write
    issue(0, 13'h010, 32'hA5A51234, 4'hF, 0, t);
    chk("w_cs_t1", cs, 1'b1);
    chk("w_wr_t1", {wr3, wr2, wr1, wr0}, 4'hF);
    chk("w_dout", bus_data_out, 32'hA5A51234);
    chk("w_addr", addr, 13'h010);
    step();
    chk("w_cs_t2", cs, 1'b1);
    chk("w_wr_t2", {wr3, wr2, wr1, wr0}, 4'h0);
    repeat (WLAT - 1) step();
    chk("w_rsp", rsp_valid, 1'b1);
    chk("w_rsp_cs", cs, 1'b0);
`ifndef WRITE_VERIFY_EN
    chk("w_rsp_data", rsp_data, 32'h0);
`endif

    // single-byte write
    issue(0, 13'h044, 32'h00CC0000, 4'h4, 0, t);
    chk("b2_wr", {wr3, wr2, wr1, wr0}, 4'h4);
    step();
    chk("b2_wr_off", {wr3, wr2, wr1, wr0}, 4'h0);
    repeat (WLAT - 1) step();
    chk("b2_rsp", rsp_valid, 1'b1);

    // no byte enables
    issue(0, 13'h055, 32'h00000001, 4'h0, 0, t);
    chk("be0_cs", cs, 1'b1);
    chk("be0_wr", {wr3, wr2, wr1, wr0}, 4'h0);
    repeat (WLAT) step();
    chk("be0_rsp", rsp_valid, 1'b1);

    // read, data valid only in last READ cycle
    bus_data_in = 32'h0BAD0BAD;
    issue(1, 13'h020, 32'h0, 4'h0, 0, t);
    chk("r_cs1", cs, 1'b1);
    chk("r_addr", addr, 13'h020);
    step();
    chk("r_cs2", cs, 1'b1);
    step();
    chk("r_cs3", cs, 1'b1);
    bus_data_in = 32'hDEADBEEF;
    step();
    chk("r_rsp", rsp_valid, 1'b1);
    chk("r_rsp_data", rsp_data, 32'hDEADBEEF);
    chk("r_rsp_cs", cs, 1'b0);
    step();
    chk("r_hold_valid", rsp_valid, 1'b0);
    chk("r_hold_data", rsp_data, 32'hDEADBEEF);

    // back-to-back writes with req_valid held
    issue(0, 13'h100, 32'h11112222, 4'hF, 1, t1);
    issue(0, 13'h100, 32'h11112222, 4'hF, 0, t2);
    chk("b2b_gap", 32'(t2 - t1), 32'(WLAT + 2));

    // reset during second READ cycle
    issue(1, 13'h030, 32'h0, 4'h0, 0, t);
    step();
    reset = 1;
    step();
    reset = 0;
    chk("abort_cs", cs, 1'b0);
    chk("abort_rsp", rsp_valid, 1'b0);
    step();
    chk("abort_ready", req_ready, 1'b1);
    chk("abort_rsp2", rsp_valid, 1'b0);

`ifdef WRITE_VERIFY_EN
    bus_data_in = 32'hFFFF5678;
    issue(0, 13'h060, 32'h12345678, 4'h3, 0, t);
    repeat (WLAT) step();
    chk("v_ok_rsp", rsp_valid, 1'b1);
    chk("v_ok_err", rsp_error, 1'b0);
    chk("v_ok_data", rsp_data, 32'hFFFF5678);
    bus_data_in = 32'h12345679;
    issue(0, 13'h060, 32'h12345678, 4'h3, 0, t);
    repeat (WLAT) step();
    chk("v_bad_rsp", rsp_valid, 1'b1);
    chk("v_bad_err", rsp_error, 1'b1);
    chk("v_bad_data", rsp_data, 32'h12345679);
`endif

    rand_bus = 1;
    for (int k = 0; k < 250; k++) begin
      repeat ($urandom_range(0, 3)) step();
      issue(1'($urandom), 13'($urandom), $urandom, 4'($urandom), 0, t);
      if (k % 41 == 7) begin
        repeat ($urandom_range(0, 2)) step();
        reset = 1;
        step();
        reset = 0;
      end
    end
    repeat (8) step();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
